// File: rtl/uart_hs_cfg.sv
// Parametrised full-duplex UART with four-phase req/ack handshakes on both sides.
// The receiver flags overrun, framing and parity errors for each presented word.
module uart_hs_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  output logic                 uart_rec_req,
  input  logic                 uart_rec_ack,
  output logic [DATA_BITS-1:0] uart_data_out,
  output logic [2:0]           uart_rec_err,
  input  logic                 uart_send_req,
  output logic                 uart_send_ack,
  input  logic [DATA_BITS-1:0] uart_data_in,
  output logic                 tx_busy
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_ACK} tx_state_e;

  // Parity bit that a correct frame carries for this payload.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // NOTE: reset asserts asynchronously but releases only after two clean clock
  // edges, so no flop leaves reset on a different cycle from its neighbours.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rst_sync_q <= 2'b11;
    else         rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  logic [1:0] rxd_sync_q;
  logic       rxd_prev_q;
  logic       rxd_s;
  logic       rx_fall;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      rxd_sync_q <= 2'b11;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_sync_q <= {rxd_sync_q[0], uart_rxd};
      rxd_prev_q <= rxd_sync_q[1];
    end
  end
  assign rxd_s   = rxd_sync_q[1];
  assign rx_fall = rxd_prev_q & ~rxd_s;

  rx_state_e            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;
  logic                 ovr_q;
  logic                 rec_req_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic [2:0]           rec_err_q;
  logic                 rx_tick;
  logic                 rx_par_err;

  assign rx_tick    = (rx_cnt_q == CNT_LAST);
  assign rx_par_err = (PARITY != 0) && (rx_par_q != par_bit(rx_shift_q));

  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      ovr_q      <= 1'b0;
      rec_req_q  <= 1'b0;
      data_out_q <= '0;
      rec_err_q  <= '0;
    end else begin
      if (rec_req_q && uart_rec_ack) rec_req_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          rx_idx_q <= '0;
          if (rx_fall) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == DATA_LAST) begin
              rx_idx_q   <= '0;
              rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else rx_idx_q <= rx_idx_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rxd_s;
            rx_state_q <= RX_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_STOP: begin
          // Only the first stop bit is sampled; leaving here lets a back-to-back start bit be caught.
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (!rec_req_q && !uart_rec_ack) begin
              data_out_q <= rx_shift_q;
              rec_err_q  <= {ovr_q, ~rxd_s, rx_par_err};
              rec_req_q  <= 1'b1;
              ovr_q      <= 1'b0;
            end else ovr_q <= 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  tx_state_e            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 txd_q;
  logic                 send_ack_q;
  logic                 tx_busy_q;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk or posedge rst_int) begin
    if (rst_int) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      send_ack_q <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          tx_idx_q <= '0;
          if (uart_send_req && !send_ack_q) begin
            tx_shift_q <= uart_data_in;
            tx_par_q   <= par_bit(uart_data_in);
            tx_busy_q  <= 1'b1;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= TX_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == DATA_LAST) begin
              tx_idx_q   <= '0;
              txd_q      <= (PARITY != 0) ? tx_par_q : 1'b1;
              tx_state_q <= (PARITY != 0) ? TX_PARITY : TX_STOP;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
            tx_state_q <= TX_STOP;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == STOP_LAST) begin
              send_ack_q <= 1'b1;
              tx_busy_q  <= 1'b0;
              tx_state_q <= TX_ACK;
            end else tx_idx_q <= tx_idx_q + 1'b1;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_ACK: begin
          if (!uart_send_req) begin
            send_ack_q <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd      = txd_q;
  assign uart_send_ack = send_ack_q;
  assign tx_busy       = tx_busy_q;
  assign uart_rec_req  = rec_req_q;
  assign uart_data_out = data_out_q;
  assign uart_rec_err  = rec_err_q;

endmodule

// File: doc/uart_hs_cfg.md
Name: uart_hs_cfg

Overview:
Parametrised full-duplex UART with four-phase req/ack handshakes on both the receive and transmit sides. Data width, parity mode, stop-bit count and baud rate are set by parameters. The receiver reports parity, framing and overrun errors. The block sits between board RX/TX pins and internal byte-stream consumers and producers, such as a debug bridge or command decoder.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz
BAUD, 115200, line rate in bit/s; CPB = CLK_FREQ/BAUD (truncated), must be >= 4
DATA_BITS, 8, payload bits per frame, legal 5..8, sent and received LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
uart_rxd  in  1  serial input; asynchronous to sys_clk
uart_txd  out  1  serial output; idles high
uart_rec_req  out  1  high = received word valid on uart_data_out
uart_rec_ack  in  1  consumer acknowledge
uart_data_out  out  DATA_BITS  received word; stable while uart_rec_req = 1
uart_rec_err  out  3  {overrun, frame_err, parity_err} for the word currently presented
uart_send_req  in  1  producer request; uart_data_in must be stable while high
uart_send_ack  out  1  high = frame fully transmitted
uart_data_in  in  DATA_BITS  word to send
tx_busy  out  1  high while the TX shifter is active

Behaviour:
- Reset (async assert; release is synchronised internally by a 2-flop sync):
  - uart_txd = 1.
  - uart_rec_req, uart_send_ack, tx_busy = 0.
  - uart_data_out = 0, uart_rec_err = 0.
  - All FSMs return to IDLE and counters clear.
  - Reset mid-frame abandons the frame: TX returns high on the next cycle, and any partial RX word is discarded.
- RX input: uart_rxd passes through a 2-flop synchroniser before use (2-cycle latency).
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE.
  - IDLE -> START on a synchronised falling edge.
  - START: sample at CPB/2. If the line is high, treat it as a glitch and return to IDLE.
  - DATA, PARITY and STOP: sample every CPB cycles after the start sample.
  - Only the first stop bit is checked. frame_err = 1 if it is sampled low.
  - parity_err is computed per the PARITY mode over the DATA_BITS payload.
  - Return to IDLE at the first stop sample, so a back-to-back frame with 1 stop bit is never missed.
- RX handshake (four-phase):
  - At the stop sample, if uart_rec_req = 0 and uart_rec_ack = 0: load uart_data_out and uart_rec_err, and raise uart_rec_req on the next cycle.
  - req stays high until ack = 1, then drops on the following cycle.
  - A new word is not presented until ack has returned to 0.
  - If a frame completes while req = 1 or ack = 1: the word is dropped, and a sticky overrun bit is set. That bit is reported in bit 2 of the next presented uart_rec_err, then cleared.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> ACK -> IDLE.
  - IDLE: if send_req = 1 and send_ack = 0, latch uart_data_in and set tx_busy = 1. uart_txd goes low on the next cycle.
  - Each bit is held for exactly CPB cycles. Stop bits are held high for STOP_BITS*CPB cycles.
  - ACK: drive send_ack = 1 and tx_busy = 0, and hold until send_req = 0. send_ack then drops on the next cycle, and the FSM enters IDLE.
  - A new request is accepted only when send_req = 1 and send_ack = 0. A req held high after ack has dropped is not re-sent until it has gone low.
  - Changes to uart_data_in after latching have no effect on the frame in progress.
- Independence: RX and TX are fully independent, and simultaneous activity on both is legal.
- Counters: the bit-period counter is wide enough to hold CPB-1; the bit index is 3 bits. Frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods.

Test Plan:
- Reset and idle: sim with CLK_FREQ=16, BAUD=1 (CPB=16); assert sys_rst mid-TX frame -> uart_txd = 1, send_ack = 0 and rec_req = 0 within 1 cycle; no output activity after release.
- TX frame, 8N1: send 0xA5 -> uart_txd shows 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles; send_ack rises after 160 cycles; ack drops 1 cycle after req drops.
- RX with even parity, 2 stop bits: drive 0x3C with correct parity -> rec_req = 1, data_out = 0x3C, err = 3'b000. Repeat with the parity bit flipped -> err = 3'b001.
- Framing error and glitch rejection: stop bit driven low -> err = 3'b010. A 5-cycle low pulse on rxd -> no rec_req.
- Overrun: leave ack low and receive 0x11 then 0x22 back-to-back; then ack, release, and send 0x33 -> 0x11 is presented with err 000, 0x22 is dropped, 0x33 is presented with err 3'b100.
- DATA_BITS=5, PARITY=1 (odd) loopback (txd tied to rxd): words 0x00, 0x1F, 0x15 -> each received word equals the sent word, err = 000, and per-frame length is 8*CPB cycles.
